truth_sweep: RTL and testbench
==============================

TRUTH_SWEEP -- requirements
Module: truth_sweep

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning the number of single-bit inputs of the function under test (legal range 2..10).
REQ-002 The block SHALL have parameter HOLD, default 1, meaning the number of clock cycles each input vector is held before sampling (legal range 1..255).
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 start  input  1  one-cycle request to begin a full sweep.
REQ-006 tt  input  2**N  expected truth table; bit k is the expected output for input vector k.
REQ-007 dut_y  input  1  observed output of the combinational function under test.
REQ-008 vec  output  N  current input vector driven to the function under test ({A,B,C,D} order for N=4, MSB first).
REQ-009 busy  output  1  high while a sweep is in progress.
REQ-010 done  output  1  one-cycle pulse when a sweep completes.
REQ-011 ones_cnt  output  N+1  number of vectors for which dut_y sampled 1.
REQ-012 err_cnt  output  N+1  number of vectors for which dut_y differed from tt[vec].
REQ-013 first_err  output  N  lowest vector index that mismatched; valid only when err_flag=1.
REQ-014 err_flag  output  1  high if at least one mismatch occurred in the last or current sweep.

Function
REQ-015 FSM states SHALL be IDLE, RUN and FIN.
REQ-016 IDLE with start=1 SHALL enter RUN next cycle with vec=0, hold counter=0, busy=1, and ones_cnt, err_cnt, first_err and err_flag cleared.
REQ-017 In RUN, vec SHALL remain stable for exactly HOLD cycles; dut_y SHALL be sampled on the last cycle of each hold window.
REQ-018 On each sample, ones_cnt SHALL increment if dut_y=1, and err_cnt SHALL increment if dut_y!=tt[vec].
REQ-019 On the first mismatch of a sweep, first_err SHALL load vec and err_flag SHALL be set; later mismatches SHALL NOT change first_err.
REQ-020 After sampling, vec SHALL advance by 1; after sampling vec=2**N-1, the FSM SHALL enter FIN and vec SHALL NOT wrap to 0 until the next start.
REQ-021 FIN SHALL last one cycle with done=1 and busy=0, then return to IDLE.
REQ-022 The start-to-done latency SHALL be exactly (2**N)*HOLD+1 cycles, counted from the cycle start is sampled to the cycle done is high.
REQ-023 start SHALL be ignored while in RUN or FIN.
REQ-024 ones_cnt, err_cnt, first_err and err_flag SHALL hold their values in IDLE until the next accepted start.
REQ-025 tt SHALL be sampled live each cycle, and changes during RUN SHALL affect only vectors not yet sampled.
REQ-026 Counters SHALL be N+1 bits wide so the value 2**N is representable without overflow.

Reset
REQ-027 rst=1 SHALL force IDLE, vec=0, busy=0, done=0, ones_cnt=0, err_cnt=0, first_err=0 and err_flag=0 on the next rising edge.
REQ-028 rst asserted mid-sweep SHALL abort the sweep with no done pulse, and rst SHALL take priority over start in the same cycle.

Structure
REQ-029 FSM state encodings SHALL live in a shared package truth_sweep_pkg, together with the HOLD counter width constant (8 bits).
REQ-030 The per-vector hold timer SHALL be a sub-module hold_timer (parameter HOLD, outputs tick on the last cycle of each window); all other logic SHALL be flat.

Verification
REQ-031 N=4, HOLD=1, tt=16'hFFFF, dut_y tied 1, start pulse: done 17 cycles after start, ones_cnt=16, err_cnt=0, err_flag=0.
REQ-032 N=4, HOLD=1, tt=16'h8000, dut_y=A&B&C&D: ones_cnt=1, err_cnt=0; then with tt=16'h8001: err_cnt=1, first_err=0, err_flag=1.
REQ-033 N=4, HOLD=3, dut_y=^vec, tt=16'h6996: each vec held 3 cycles, done at cycle 49, ones_cnt=8, err_cnt=0.
REQ-034 N=4, dut_y=0, tt=16'h0F0F: err_cnt=8, first_err=0; start re-pulsed during RUN produces no restart, and vec continues monotonically.
REQ-035 rst pulsed when vec=7: next cycle shows IDLE, vec=0, all counters 0, busy=0, and no done pulse occurs.
REQ-036 N=2, HOLD=1, dut_y=1, tt=4'hF: done 5 cycles after start, ones_cnt=3'd4, with no counter overflow.

Source files
------------

// File: rtl/truth_sweep_pkg.sv
// Shared definitions for the truth-table sweeper: FSM encoding and hold timer width.
package truth_sweep_pkg;

  // Width of the per-vector hold counter; covers HOLD up to 255.
  localparam int HOLD_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/truth_sweep_hold_timer.sv
// Per-vector hold timer: while running, counts HOLD cycles and raises tick on
// the last cycle of each window. Held at zero whenever not running, so a new
// sweep always begins with a fresh window.
module hold_timer
  import truth_sweep_pkg::*;
#(
  parameter int HOLD = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  output logic tick
);

  localparam logic [HOLD_W-1:0] LAST    = HOLD_W'(HOLD - 1);
  localparam logic [HOLD_W-1:0] CNT_ONE = HOLD_W'(1);

  logic [HOLD_W-1:0] cnt_q;
  logic [HOLD_W-1:0] cnt_d;

  // Window end detection and next count value.
  always_comb begin
    tick  = run_i && (cnt_q == LAST);
    cnt_d = cnt_q + CNT_ONE;
    if (!run_i || tick) begin
      cnt_d = '0;
    end
  end

  // Hold counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/truth_sweep.sv
// Exhaustive truth-table sweeper: drives every N-bit input vector to a
// combinational function, samples its output once per hold window, and counts
// ones and mismatches against an expected truth table.
module truth_sweep
  import truth_sweep_pkg::*;
#(
  parameter int N    = 4,
  parameter int HOLD = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2**N-1:0] tt,
  input  logic            dut_y,
  output logic [N-1:0]    vec,
  output logic            busy,
  output logic            done,
  output logic [N:0]      ones_cnt,
  output logic [N:0]      err_cnt,
  output logic [N-1:0]    first_err,
  output logic            err_flag
);

  localparam logic [N-1:0] VEC_LAST = '1;
  localparam logic [N-1:0] VEC_ONE  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N:0]   CNT_ONE  = {{N{1'b0}}, 1'b1};

  state_t       state_q;
  logic [N-1:0] vec_q;
  logic         busy_q;
  logic         done_q;
  logic [N:0]   ones_q;
  logic [N:0]   err_q;
  logic [N-1:0] ferr_q;
  logic         eflag_q;

  logic         run;
  logic         tick;
  logic         mism;
  logic         last_vec;

  assign run = (state_q == ST_RUN);

  hold_timer #(
    .HOLD (HOLD)
  ) u_hold (
    .clk   (clk),
    .rst   (rst),
    .run_i (run),
    .tick  (tick)
  );

  // Compare the observed output against the live truth table entry.
  always_comb begin
    mism     = dut_y ^ tt[vec_q];
    last_vec = (vec_q == VEC_LAST);
  end

  // Sweep controller with registered outputs and result counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ones_q  <= '0;
      err_q   <= '0;
      ferr_q  <= '0;
      eflag_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_RUN;
            vec_q   <= '0;
            busy_q  <= 1'b1;
            ones_q  <= '0;
            err_q   <= '0;
            ferr_q  <= '0;
            eflag_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (tick) begin
            if (dut_y) begin
              ones_q <= ones_q + CNT_ONE;
            end
            if (mism) begin
              err_q <= err_q + CNT_ONE;
              // Only the first mismatch of a sweep is recorded.
              if (!eflag_q) begin
                ferr_q  <= vec_q;
                eflag_q <= 1'b1;
              end
            end
            // The last vector stays on vec until the next sweep starts.
            if (last_vec) begin
              state_q <= ST_FIN;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              vec_q <= vec_q + VEC_ONE;
            end
          end
        end
        ST_FIN: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign vec       = vec_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ones_cnt  = ones_q;
  assign err_cnt   = err_q;
  assign first_err = ferr_q;
  assign err_flag  = eflag_q;

endmodule

// File: tb/tb_truth_sweep.sv
// Bench for truth_sweep: three instances (N=4/HOLD=1, N=4/HOLD=3, N=2/HOLD=1)
// with the function under test modelled as a lookup into a random truth table.
module tb_truth_sweep;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Instance A: N=4, HOLD=1
  logic        start_a;
  logic [15:0] tt_a, ytab_a;
  logic        y_a;
  logic [3:0]  vec_a;
  logic        busy_a, done_a;
  logic [4:0]  ones_a, err_a;
  logic [3:0]  ferr_a;
  logic        eflag_a;
  assign y_a = ytab_a[vec_a];

  truth_sweep #(.N(4), .HOLD(1)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .tt(tt_a), .dut_y(y_a),
    .vec(vec_a), .busy(busy_a), .done(done_a), .ones_cnt(ones_a),
    .err_cnt(err_a), .first_err(ferr_a), .err_flag(eflag_a)
  );

  // Instance B: N=4, HOLD=3
  logic        start_b;
  logic [15:0] tt_b, ytab_b;
  logic        y_b;
  logic [3:0]  vec_b;
  logic        busy_b, done_b;
  logic [4:0]  ones_b, err_b;
  logic [3:0]  ferr_b;
  logic        eflag_b;
  assign y_b = ytab_b[vec_b];

  truth_sweep #(.N(4), .HOLD(3)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .tt(tt_b), .dut_y(y_b),
    .vec(vec_b), .busy(busy_b), .done(done_b), .ones_cnt(ones_b),
    .err_cnt(err_b), .first_err(ferr_b), .err_flag(eflag_b)
  );

  // Instance C: N=2, HOLD=1
  logic        start_c;
  logic [3:0]  tt_c, ytab_c;
  logic        y_c;
  logic [1:0]  vec_c;
  logic        busy_c, done_c;
  logic [2:0]  ones_c, err_c;
  logic [1:0]  ferr_c;
  logic        eflag_c;
  assign y_c = ytab_c[vec_c];

  truth_sweep #(.N(2), .HOLD(1)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .tt(tt_c), .dut_y(y_c),
    .vec(vec_c), .busy(busy_c), .done(done_c), .ones_cnt(ones_c),
    .err_cnt(err_c), .first_err(ferr_c), .err_flag(eflag_c)
  );

  int total = 0;
  int bad   = 0;
  int holdc [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int popc(input logic [15:0] v);
    int c = 0;
    for (int i = 0; i < 16; i++) if (v[i]) c++;
    return c;
  endfunction

  function automatic int lowest(input logic [15:0] v);
    for (int i = 0; i < 16; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Full sweep on instance A. y is the function's truth table, t0 the expected
  // table; from vector chg_k onward the expected table becomes t1 (chg_k<0: never).
  // rs_k >= 0 re-pulses start while vec==rs_k, which must be ignored.
  task automatic run_a(input string tag, input logic [15:0] y, input logic [15:0] t0,
                       input logic [15:0] t1, input int chg_k, input int rs_k);
    int          lat;
    int          prev;
    bit          mono;
    logic [15:0] lowm, eff, mis;
    ytab_a = y;
    tt_a   = t0;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk({tag, "_busy_c1"}, busy_a, 1);
    chk({tag, "_vec_c1"}, vec_a, 0);
    chk({tag, "_ones_clr"}, ones_a, 0);
    lat  = 1;
    prev = 0;
    mono = 1'b1;
    while (!done_a && lat < 200) begin
      if (chg_k >= 0 && int'(vec_a) >= chg_k) tt_a = t1;
      start_a = (rs_k >= 0 && int'(vec_a) == rs_k);
      if (int'(vec_a) < prev) mono = 1'b0;
      prev = int'(vec_a);
      @(negedge clk);
      lat++;
    end
    start_a = 1'b0;
    lowm = (chg_k > 0) ? ((16'h1 << chg_k) - 16'h1) : 16'h0;
    eff  = (chg_k >= 0) ? ((t0 & lowm) | (t1 & ~lowm)) : t0;
    mis  = y ^ eff;
    chk({tag, "_latency"}, lat, 17);
    chk({tag, "_ones"}, ones_a, popc(y));
    chk({tag, "_errs"}, err_a, popc(mis));
    chk({tag, "_eflag"}, eflag_a, (mis != 16'h0));
    chk({tag, "_ferr"}, ferr_a, lowest(mis));
    chk({tag, "_mono"}, mono, 1);
    @(negedge clk);
    chk({tag, "_idle_busy"}, busy_a, 0);
    chk({tag, "_idle_done"}, done_a, 0);
    chk({tag, "_idle_ones"}, ones_a, popc(y));
    chk({tag, "_idle_vec"}, vec_a, 15);
  endtask

  initial begin
    int          lat, n, dones;
    logic [31:0] r1, r2, r3;
    logic [3:0]  yc, tc;

    rst     = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    tt_a = '0; tt_b = '0; tt_c = '0;
    ytab_a = '0; ytab_b = '0; ytab_c = '0;
    repeat (3) @(negedge clk);
    chk("rst_vec", vec_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_ones", ones_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_ferr", ferr_a, 0);
    chk("rst_eflag", eflag_a, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed sweeps
    run_a("tie1", 16'hFFFF, 16'hFFFF, 16'h0, -1, -1);
    run_a("and4", 16'h8000, 16'h8000, 16'h0, -1, -1);
    run_a("and4e", 16'h8000, 16'h8001, 16'h0, -1, -1);
    run_a("zero_rs", 16'h0000, 16'h0F0F, 16'h0, -1, 5);

    // Expected table changed mid-sweep
    r1 = $urandom; r2 = $urandom; r3 = $urandom;
    run_a("ttlive", r1[15:0], r2[15:0], r3[15:0], int'($urandom_range(1, 14)), -1);

    // Random functions with sparse mismatches
    for (int i = 0; i < 6; i++) begin
      r1 = $urandom;
      r2 = $urandom & $urandom & $urandom;
      run_a("rnd", r1[15:0], r1[15:0] ^ r2[15:0], 16'h0, -1,
            (i % 2 == 1) ? int'($urandom_range(1, 14)) : -1);
    end

    // HOLD=3 parity sweep
    ytab_b = 16'h6996;
    tt_b   = 16'h6996;
    for (int i = 0; i < 16; i++) holdc[i] = 0;
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    lat = 1;
    while (!done_b && lat < 300) begin
      if (busy_b) holdc[vec_b]++;
      @(negedge clk);
      lat++;
    end
    n = 0;
    for (int i = 0; i < 16; i++) if (holdc[i] == 3) n++;
    chk("h3_latency", lat, 49);
    chk("h3_hold3", n, 16);
    chk("h3_ones", ones_b, 8);
    chk("h3_errs", err_b, 0);
    chk("h3_eflag", eflag_b, 0);

    // N=2 full-count sweep, then one random sweep
    ytab_c = 4'hF;
    tt_c   = 4'hF;
    @(negedge clk);
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    lat = 1;
    while (!done_c && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("n2_latency", lat, 5);
    chk("n2_ones", ones_c, 4);
    chk("n2_errs", err_c, 0);
    chk("n2_eflag", eflag_c, 0);

    r1 = $urandom; r2 = $urandom;
    yc = r1[3:0]; tc = r2[3:0];
    ytab_c = yc;
    tt_c   = tc;
    @(negedge clk);
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    lat = 1;
    while (!done_c && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("n2r_latency", lat, 5);
    chk("n2r_ones", ones_c, popc({12'h0, yc}));
    chk("n2r_errs", err_c, popc({12'h0, yc ^ tc}));
    chk("n2r_ferr", ferr_c, lowest({12'h0, yc ^ tc}));

    // Reset mid-sweep at vec=7
    ytab_a = 16'hFFFF;
    tt_a   = 16'h0000;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    n = 0;
    while (vec_a != 4'd7 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reach7", vec_a, 7);
    chk("mid_ones7", ones_a, 7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_vec", vec_a, 0);
    chk("mid_busy", busy_a, 0);
    chk("mid_ones", ones_a, 0);
    chk("mid_err", err_a, 0);
    chk("mid_ferr", ferr_a, 0);
    chk("mid_eflag", eflag_a, 0);
    dones = 0;
    repeat (25) begin
      @(negedge clk);
      if (done_a) dones++;
    end
    chk("mid_nodone", dones, 0);
    chk("mid_still_idle", busy_a, 0);

    // Reset wins over start in the same cycle
    rst     = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    start_a = 1'b0;
    chk("prio_busy", busy_a, 0);
    @(negedge clk);
    chk("prio_busy2", busy_a, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
